// File: rtl/vote_fsm.sv
// Voting session control and tally: button edge detect, session FSM, vote counters and winner pick.
// Optional VOTE_AUTO_CLOSE_EN: the accepted vote that reaches MAX_VOTES also closes the session.
module vote_fsm #(
  parameter int unsigned MAX_VOTES = 19,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_close,
  input  logic             btn_result,
  input  logic [3:0]       vote_btn,
  output logic [1:0]       the_state,
  output logic [1:0]       the_winner,
  output logic [CNT_W-1:0] vote_count,
  output logic             vote_ack
);

  localparam int unsigned NUM_CAND = 4;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_OPEN   = 2'b01,
    S_CLOSED = 2'b10,
    S_WINNER = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cand_cnt [NUM_CAND];
  logic [CNT_W-1:0]      w_cand_nxt [NUM_CAND];
  logic [CNT_W-1:0]      r_total;
  logic [CNT_W-1:0]      w_total_nxt;
  logic [IDX_W-1:0]      r_winner;
  logic [IDX_W-1:0]      w_winner_nxt;
  logic [CNT_W-1:0]      r_vote_count;
  logic [CNT_W-1:0]      w_vote_count_nxt;
  logic                  r_vote_ack;
  logic                  w_vote_ack_nxt;

  logic                  r_hist_start;
  logic                  r_hist_close;
  logic                  r_hist_result;
  logic [NUM_CAND-1:0]   r_hist_vote;

  logic                  w_start_edge;
  logic                  w_close_edge;
  logic                  w_result_edge;
  logic [NUM_CAND-1:0]   w_vote_edge;
  logic                  w_vote_single;
  logic                  w_total_room;
  logic [IDX_W-1:0]      w_vote_idx;
  logic [IDX_W-1:0]      w_best_idx;
  logic [CNT_W-1:0]      w_best_cnt;

  // Rising-edge detection against last-cycle button levels
  assign w_start_edge  = btn_start  & ~r_hist_start;
  assign w_close_edge  = btn_close  & ~r_hist_close;
  assign w_result_edge = btn_result & ~r_hist_result;
  assign w_vote_edge   = vote_btn   & ~r_hist_vote;

  assign w_vote_single = (w_vote_edge != '0) &&
                         ((w_vote_edge & (w_vote_edge - NUM_CAND'(1))) == '0);
  assign w_total_room  = (r_total < CNT_W'(MAX_VOTES));

  // Index of the single voting candidate
  always_comb begin
    w_vote_idx = '0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (w_vote_edge[i]) w_vote_idx = IDX_W'(i);
    end
  end

  // Max count; strict compare keeps the lowest index on ties
  always_comb begin
    w_best_idx = '0;
    w_best_cnt = r_cand_cnt[0];
    for (int i = 1; i < int'(NUM_CAND); i++) begin
      if (r_cand_cnt[i] > w_best_cnt) begin
        w_best_idx = IDX_W'(i);
        w_best_cnt = r_cand_cnt[i];
      end
    end
  end

  // Next state, counters and outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand_cnt;
    w_total_nxt    = r_total;
    w_winner_nxt   = r_winner;
    w_vote_ack_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = S_OPEN;
          for (int i = 0; i < int'(NUM_CAND); i++) w_cand_nxt[i] = '0;
          w_total_nxt = '0;
        end
      end
      S_OPEN: begin
        if (w_vote_single && w_total_room) begin
          w_cand_nxt[w_vote_idx] = r_cand_cnt[w_vote_idx] + CNT_W'(1);
          w_total_nxt            = r_total + CNT_W'(1);
          w_vote_ack_nxt         = 1'b1;
`ifdef VOTE_AUTO_CLOSE_EN
          if (r_total + CNT_W'(1) == CNT_W'(MAX_VOTES)) w_state_nxt = S_CLOSED;
`endif
        end
        if (w_close_edge) w_state_nxt = S_CLOSED;
      end
      S_CLOSED: begin
        if (w_result_edge) begin
          w_state_nxt  = S_WINNER;
          w_winner_nxt = w_best_idx;
        end
      end
      S_WINNER: begin
        if (w_start_edge) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Counts are frozen in CLOSED/WINNER, so the live max is the winner's count
    case (w_state_nxt)
      S_IDLE:            w_vote_count_nxt = '0;
      S_OPEN, S_CLOSED:  w_vote_count_nxt = w_total_nxt;
      S_WINNER:          w_vote_count_nxt = w_best_cnt;
      default:           w_vote_count_nxt = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath registers; history tracks levels even in reset so held buttons give no edge
  always_ff @(posedge clk_100MHz) begin
    r_hist_start  <= btn_start;
    r_hist_close  <= btn_close;
    r_hist_result <= btn_result;
    r_hist_vote   <= vote_btn;
    if (reset) begin
      for (int i = 0; i < int'(NUM_CAND); i++) r_cand_cnt[i] <= '0;
      r_total      <= '0;
      r_winner     <= '0;
      r_vote_count <= '0;
      r_vote_ack   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CAND); i++) r_cand_cnt[i] <= w_cand_nxt[i];
      r_total      <= w_total_nxt;
      r_winner     <= w_winner_nxt;
      r_vote_count <= w_vote_count_nxt;
      r_vote_ack   <= w_vote_ack_nxt;
    end
  end

  assign the_state  = r_state;
  assign the_winner = r_winner;
  assign vote_count = r_vote_count;
  assign vote_ack   = r_vote_ack;

endmodule

// File: tb/tb_vote_fsm.sv
// Scoreboard bench for vote_fsm: a behavioural model pushes expected outputs per cycle, popped after each edge.
module tb_vote_fsm;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       btn_start  = 1'b0;
  logic       btn_close  = 1'b0;
  logic       btn_result = 1'b0;
  logic [3:0] vote_btn   = 4'b0;
  logic [1:0] the_state;
  logic [1:0] the_winner;
  logic [4:0] vote_count;
  logic       vote_ack;

  vote_fsm #(.MAX_VOTES(19), .CNT_W(5)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_close  (btn_close),
    .btn_result (btn_result),
    .vote_btn   (vote_btn),
    .the_state  (the_state),
    .the_winner (the_winner),
    .vote_count (vote_count),
    .vote_ack   (vote_ack)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] win;
    logic [4:0] vc;
    logic       ack;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ack    = 0;
  int   last_ack_state = -1;

  // Reference model state
  int   m_state = 0;
  int   m_cnt[4];
  int   m_total = 0;
  int   m_win = 0;
  int   m_vc = 0;
  int   m_ack = 0;
  logic m_hs = 0, m_hc = 0, m_hr = 0;
  logic [3:0] m_hv = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic rst, input logic st, input logic cl, input logic rs,
                       input logic [3:0] v);
    logic se, ce, re;
    logic [3:0] ve;
    int mx;
    se = st & ~m_hs; ce = cl & ~m_hc; re = rs & ~m_hr; ve = v & ~m_hv;
    m_hs = st; m_hc = cl; m_hr = rs; m_hv = v;
    m_ack = 0;
    if (rst) begin
      m_state = 0; m_total = 0; m_win = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      case (m_state)
        0: if (se) begin
             m_state = 1; m_total = 0;
             for (int i = 0; i < 4; i++) m_cnt[i] = 0;
           end
        1: begin
             if ($countones(ve) == 1 && m_total < 19) begin
               for (int i = 0; i < 4; i++) if (ve[i]) m_cnt[i]++;
               m_total++;
               m_ack = 1;
`ifdef VOTE_AUTO_CLOSE_EN
               if (m_total == 19) m_state = 2;
`endif
             end
             if (ce) m_state = 2;
           end
        2: if (re) begin
             mx = 0;
             for (int i = 0; i < 4; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
             m_win = -1;
             for (int i = 3; i >= 0; i--) if (m_cnt[i] == mx) m_win = i;
             m_state = 3;
           end
        default: if (se) m_state = 0;
      endcase
    end
    case (m_state)
      0:       m_vc = 0;
      1, 2:    m_vc = m_total;
      default: m_vc = m_cnt[m_win];
    endcase
  endtask

  task automatic step(input logic rst, input logic st, input logic cl, input logic rs,
                      input logic [3:0] v);
    exp_t e;
    reset = rst; btn_start = st; btn_close = cl; btn_result = rs; vote_btn = v;
    model(rst, st, cl, rs, v);
    e.st = 2'(m_state); e.win = 2'(m_win); e.vc = 5'(m_vc); e.ack = 1'(m_ack);
    q.push_back(e);
    @(posedge clk_100MHz);
    #1;
    if (q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = q.pop_front();
      check_eq("state", int'(the_state), int'(e.st));
      check_eq("winner", int'(the_winner), int'(e.win));
      check_eq("vote_count", int'(vote_count), int'(e.vc));
      check_eq("vote_ack", int'(vote_ack), int'(e.ack));
    end
    if (vote_ack) begin
      n_ack++;
      last_ack_state = int'(the_state);
    end
  endtask

  task automatic press(input logic st, input logic cl, input logic rs, input logic [3:0] v);
    step(1'b0, st, cl, rs, v);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
  endtask

  task automatic vote(input int c);
    logic [3:0] b;
    b = 4'b0001 << c;
    press(1'b0, 1'b0, 1'b0, b);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);
    check_eq("rst_state", int'(the_state), 0);
    check_eq("rst_count", int'(vote_count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
    check_eq("open_state", int'(the_state), 1);
    check_eq("open_count", int'(vote_count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    // Votes 2,2,1,3,2 then close and result
    n_ack = 0;
    vote(2); vote(2); vote(1); vote(3); vote(2);
    check_eq("five_count", int'(vote_count), 5);
    check_eq("five_acks", n_ack, 5);
    press(1'b0, 1'b1, 1'b0, 4'b0);
    press(1'b0, 1'b0, 1'b1, 4'b0);
    check_eq("win1_state", int'(the_state), 3);
    check_eq("win1_winner", int'(the_winner), 2);
    check_eq("win1_count", int'(vote_count), 3);

    // Tie between 1 and 3 resolves to 1
    press(1'b1, 1'b0, 1'b0, 4'b0);
    press(1'b1, 1'b0, 1'b0, 4'b0);
    vote(1); vote(3); vote(3); vote(1);
    press(1'b0, 1'b1, 1'b0, 4'b0);
    press(1'b0, 1'b0, 1'b1, 4'b0);
    check_eq("tie_winner", int'(the_winner), 1);
    check_eq("tie_count", int'(vote_count), 2);

    // Simultaneous edges rejected; held button counts once
    press(1'b1, 1'b0, 1'b0, 4'b0);
    press(1'b1, 1'b0, 1'b0, 4'b0);
    n_ack = 0;
    press(1'b0, 1'b0, 1'b0, 4'b0101);
    check_eq("multi_acks", n_ack, 0);
    check_eq("multi_count", int'(vote_count), 0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    check_eq("held_count", int'(vote_count), 1);
    check_eq("held_acks", n_ack, 1);

    // Saturation: 20 votes for candidate 0 in a fresh session
    press(1'b0, 1'b1, 1'b0, 4'b0);
    press(1'b0, 1'b0, 1'b1, 4'b0);
    press(1'b1, 1'b0, 1'b0, 4'b0);
    press(1'b1, 1'b0, 1'b0, 4'b0);
    n_ack = 0;
    for (int i = 0; i < 20; i++) vote(0);
    check_eq("sat_count", int'(vote_count), 19);
    check_eq("sat_acks", n_ack, 19);
`ifdef VOTE_AUTO_CLOSE_EN
    check_eq("sat_ack_state", last_ack_state, 2);
    check_eq("sat_state", int'(the_state), 2);
`else
    check_eq("sat_ack_state", last_ack_state, 1);
    check_eq("sat_state", int'(the_state), 1);
`endif
    press(1'b0, 1'b1, 1'b0, 4'b0);
    press(1'b0, 1'b0, 1'b1, 4'b0);
    check_eq("sat_win_state", int'(the_state), 3);
    check_eq("sat_win_count", int'(vote_count), 19);

    // Reset in WINNER with start held: no OPEN until re-pressed
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
    check_eq("mid_rst_state", int'(the_state), 0);
    check_eq("mid_rst_count", int'(vote_count), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
    check_eq("held_start_state", int'(the_state), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0);
    check_eq("repress_state", int'(the_state), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0);

    check_eq("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
